// File: rtl/ppi8255_if.sv
// CPU-side bus of the 8255-style PPI: chip select, direction, address and data.
interface ppi8255_if;
  logic       cs;
  logic       rnw;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  // One access per clk edge at which cs is high; rnw picks read or write and
  // there are no wait states. dout is combinational from addr and is valid
  // throughout the cycle whose closing edge performs the read.
  modport master (output cs, output rnw, output addr, output din, input dout);
  modport slave  (input cs, input rnw, input addr, input din, output dout);
endinterface

// File: rtl/ppi8255.sv
// 8255-style programmable peripheral interface: mode 0 ports with per-group
// direction, port C bit set/reset, and mode 1 strobed handshakes on A and B.
module ppi8255 #(
  parameter logic [7:0] RESET_CTRL  = 8'h9B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  ppi8255_if.slave   bus,
  input  logic [7:0] pa_i,
  output logic [7:0] pa_o,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_i,
  output logic [7:0] pb_o,
  output logic [7:0] pb_oe,
  input  logic [7:0] pc_i,
  output logic [7:0] pc_o,
  output logic [7:0] pc_oe,
  output logic       intr_a,
  output logic       intr_b
);

  // ---------------------------------------------------------------- pins
  logic [SYNC_STAGES-1:0][7:0] pa_pipe, pb_pipe, pc_pipe;
  logic [7:0] pa_s, pb_s, pc_s, pc_prev;

  assign pa_s = pa_pipe[SYNC_STAGES-1];
  assign pb_s = pb_pipe[SYNC_STAGES-1];
  assign pc_s = pc_pipe[SYNC_STAGES-1];

  // pc_prev holds the previous synchronised sample so handshake edges are
  // decoded one clk after the new level leaves the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pa_pipe <= '0;
      pb_pipe <= '0;
      pc_pipe <= '0;
      pc_prev <= '0;
    end else begin
      pa_pipe[0] <= pa_i;
      pb_pipe[0] <= pb_i;
      pc_pipe[0] <= pc_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pa_pipe[i] <= pa_pipe[i-1];
        pb_pipe[i] <= pb_pipe[i-1];
        pc_pipe[i] <= pc_pipe[i-1];
      end
      pc_prev <= pc_s;
    end
  end

  logic stb_a_fall, stb_a_rise, ack_a_fall, ack_a_rise, hs_b_fall, hs_b_rise;

  assign stb_a_fall =  pc_prev[4] & ~pc_s[4];
  assign stb_a_rise = ~pc_prev[4] &  pc_s[4];
  assign ack_a_fall =  pc_prev[6] & ~pc_s[6];
  assign ack_a_rise = ~pc_prev[6] &  pc_s[6];
  assign hs_b_fall  =  pc_prev[2] & ~pc_s[2];
  assign hs_b_rise  = ~pc_prev[2] &  pc_s[2];

  // ---------------------------------------------------------------- state
  logic [7:0] ctrl;
  logic [7:0] pa_lat, pb_lat, pc_lat, pa_in_lat, pb_in_lat;
  logic       inte_a, inte_b, ibf_a, ibf_b, obf_a_n, obf_b_n;
  logic       intr_a_r, intr_b_r;

  // Mode 2 (D6 set) is not supported and falls back to mode 0.
  logic mode_a, a_in, pcu_in, mode_b, b_in, pcl_in;

  assign mode_a = (ctrl[6:5] == 2'b01);
  assign a_in   = ctrl[4];
  assign pcu_in = ctrl[3];
  assign mode_b = ctrl[2];
  assign b_in   = ctrl[1];
  assign pcl_in = ctrl[0];

  logic wr, rd, wr_pa, wr_pb, wr_pc, wr_ctl, wr_bsr, rd_pa, rd_pb;
  logic [2:0] bsr_idx;

  assign wr      = bus.cs & ~bus.rnw;
  assign rd      = bus.cs &  bus.rnw;
  assign wr_pa   = wr & (bus.addr == 2'd0);
  assign wr_pb   = wr & (bus.addr == 2'd1);
  assign wr_pc   = wr & (bus.addr == 2'd2);
  assign wr_ctl  = wr & (bus.addr == 2'd3) &  bus.din[7];
  assign wr_bsr  = wr & (bus.addr == 2'd3) & ~bus.din[7];
  assign rd_pa   = rd & (bus.addr == 2'd0);
  assign rd_pb   = rd & (bus.addr == 2'd1);
  assign bsr_idx = bus.din[3:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl      <= RESET_CTRL;
      pa_lat    <= '0;
      pb_lat    <= '0;
      pc_lat    <= '0;
      pa_in_lat <= '0;
      pb_in_lat <= '0;
      inte_a    <= 1'b0;
      inte_b    <= 1'b0;
      ibf_a     <= 1'b0;
      ibf_b     <= 1'b0;
      obf_a_n   <= 1'b1;
      obf_b_n   <= 1'b1;
      intr_a_r  <= 1'b0;
      intr_b_r  <= 1'b0;
    end else if (wr_ctl) begin
      // A control word overrides any handshake event on the same edge.
      ctrl     <= bus.din;
      pa_lat   <= '0;
      pb_lat   <= '0;
      pc_lat   <= '0;
      inte_a   <= 1'b0;
      inte_b   <= 1'b0;
      ibf_a    <= 1'b0;
      ibf_b    <= 1'b0;
      obf_a_n  <= 1'b1;
      obf_b_n  <= 1'b1;
      intr_a_r <= 1'b0;
      intr_b_r <= 1'b0;
    end else begin
      if (wr_pa) pa_lat <= bus.din;
      if (wr_pb) pb_lat <= bus.din;
      if (wr_pc) pc_lat <= bus.din;

      // Set/reset of a strobe/ACK input position programs INTE instead.
      if (wr_bsr) begin
        if (mode_a && a_in && bsr_idx == 3'd4)
          inte_a <= bus.din[0];
        else if (mode_a && !a_in && bsr_idx == 3'd6)
          inte_a <= bus.din[0];
        else if (mode_b && bsr_idx == 3'd2)
          inte_b <= bus.din[0];
        else
          pc_lat[bsr_idx] <= bus.din[0];
      end

      if (mode_a && a_in) begin
        if (stb_a_fall) begin
          pa_in_lat <= pa_s;
          ibf_a     <= 1'b1;
        end else if (rd_pa) begin
          ibf_a     <= 1'b0;
        end
        if (rd_pa)
          intr_a_r <= 1'b0;
        else if (stb_a_rise && inte_a && ibf_a)
          intr_a_r <= 1'b1;
      end else if (mode_a) begin
        if (wr_pa)
          obf_a_n <= 1'b0;
        else if (ack_a_fall)
          obf_a_n <= 1'b1;
        if (wr_pa)
          intr_a_r <= 1'b0;
        else if (ack_a_rise && inte_a && obf_a_n)
          intr_a_r <= 1'b1;
      end

      if (mode_b && b_in) begin
        if (hs_b_fall) begin
          pb_in_lat <= pb_s;
          ibf_b     <= 1'b1;
        end else if (rd_pb) begin
          ibf_b     <= 1'b0;
        end
        if (rd_pb)
          intr_b_r <= 1'b0;
        else if (hs_b_rise && inte_b && ibf_b)
          intr_b_r <= 1'b1;
      end else if (mode_b) begin
        if (wr_pb)
          obf_b_n <= 1'b0;
        else if (hs_b_fall)
          obf_b_n <= 1'b1;
        if (wr_pb)
          intr_b_r <= 1'b0;
        else if (hs_b_rise && inte_b && obf_b_n)
          intr_b_r <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    pa_o  = pa_lat;
    pb_o  = pb_lat;
    pa_oe = {8{~a_in}};
    pb_oe = {8{~b_in}};
    pc_o  = pc_lat;
    pc_oe = {{4{~pcu_in}}, {4{~pcl_in}}};
    if (mode_a) begin
      pc_oe[3] = 1'b1;
      pc_o[3]  = intr_a_r;
      if (a_in) begin
        pc_oe[4] = 1'b0;
        pc_oe[5] = 1'b1;
        pc_o[5]  = ibf_a;
      end else begin
        pc_oe[6] = 1'b0;
        pc_oe[7] = 1'b1;
        pc_o[7]  = obf_a_n;
      end
    end
    if (mode_b) begin
      pc_oe[0] = 1'b1;
      pc_o[0]  = intr_b_r;
      pc_oe[1] = 1'b1;
      pc_o[1]  = b_in ? ibf_b : obf_b_n;
      pc_oe[2] = 1'b0;
    end
  end

  assign intr_a = intr_a_r;
  assign intr_b = intr_b_r;

  // PC reads return the mode 1 status word in handshake positions.
  logic [7:0] pa_rd, pb_rd, pc_rd;

  always_comb begin
    pa_rd = a_in ? (mode_a ? pa_in_lat : pa_s) : pa_lat;
    pb_rd = b_in ? (mode_b ? pb_in_lat : pb_s) : pb_lat;
    pc_rd = {pcu_in ? pc_s[7:4] : pc_lat[7:4],
             pcl_in ? pc_s[3:0] : pc_lat[3:0]};
    if (mode_a) begin
      pc_rd[3] = intr_a_r;
      if (a_in) begin
        pc_rd[5] = ibf_a;
        pc_rd[4] = inte_a;
      end else begin
        pc_rd[7] = obf_a_n;
        pc_rd[6] = inte_a;
      end
    end
    if (mode_b) begin
      pc_rd[2] = inte_b;
      pc_rd[1] = b_in ? ibf_b : obf_b_n;
      pc_rd[0] = intr_b_r;
    end
  end

  always_comb begin
    bus.dout = 8'h00;
    case (bus.addr)
      2'd0:    bus.dout = pa_rd;
      2'd1:    bus.dout = pb_rd;
      2'd2:    bus.dout = pc_rd;
      default: bus.dout = ctrl;
    endcase
  end

endmodule

// File: tb/tb_ppi8255.sv
// Bench for ppi8255: directed handshake scenarios plus randomized mode 0 and
// mode 1 traffic compared against a port-level model.
module tb_ppi8255;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pa_i, pb_i, pc_i;
  logic [7:0] pa_o, pa_oe, pb_o, pb_oe, pc_o, pc_oe;
  logic       intr_a, intr_b;

  ppi8255_if bus ();

  ppi8255 #(.RESET_CTRL(8'h9B), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .pa_i    (pa_i),
    .pa_o    (pa_o),
    .pa_oe   (pa_oe),
    .pb_i    (pb_i),
    .pb_o    (pb_o),
    .pb_oe   (pb_oe),
    .pc_i    (pc_i),
    .pc_o    (pc_o),
    .pc_oe   (pc_oe),
    .intr_a  (intr_a),
    .intr_b  (intr_b)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.rnw = 1'b0; bus.addr = a; bus.din = d;
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.rnw = 1'b1; bus.addr = a;
    #1;
    d = bus.dout;
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b0; bus.rnw = 1'b1; bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0] m_ctrl, m_pa, m_pb, m_pc;

  function automatic logic [7:0] nib_sel(input logic up_in, input logic lo_in,
                                         input logic [7:0] pins, input logic [7:0] lat);
    return {up_in ? pins[7:4] : lat[7:4], lo_in ? pins[3:0] : lat[3:0]};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] got, w, d, r;
    int         mm, op, bi;
    logic [1:0] md;
    logic       v;

    bus.cs = 1'b0; bus.rnw = 1'b1; bus.addr = 2'd0; bus.din = 8'h00;
    pa_i = 8'h5A; pb_i = 8'h00; pc_i = 8'hFF;
    reset_n = 1'b0;
    tick(2);

    // reset state with 9B: everything an input, latches clear
    chk("rst_pa_oe", pa_oe, 8'h00);
    chk("rst_pb_oe", pb_oe, 8'h00);
    chk("rst_pc_oe", pc_oe, 8'h00);
    chk("rst_pa_o", pa_o, 8'h00);
    chk("rst_pb_o", pb_o, 8'h00);
    chk("rst_pc_o", pc_o, 8'h00);
    chk1("rst_intr_a", intr_a, 1'b0);
    chk1("rst_intr_b", intr_b, 1'b0);
    peek(2'd0, got);
    chk("rst_pa_read_sync_clear", got, 8'h00);

    reset_n = 1'b1;
    tick(SYNC - 1);
    peek(2'd0, got);
    chk("pa_read_before_sync", got, 8'h00);
    tick(1);
    peek(2'd0, got);
    chk("pa_read_after_sync", got, 8'h5A);

    // mode 0: PA out, PB in, PC out
    wr(2'd3, 8'h82);
    wr(2'd0, 8'h3C);
    wr(2'd2, 8'hF0);
    chk("m0_pa_oe", pa_oe, 8'hFF);
    chk("m0_pa_o", pa_o, 8'h3C);
    chk("m0_pc_o", pc_o, 8'hF0);
    chk("m0_pb_oe", pb_oe, 8'h00);
    chk("m0_pc_oe", pc_oe, 8'hFF);
    wr(2'd3, 8'h82);
    chk("ctl_clr_pa_o", pa_o, 8'h00);
    chk("ctl_clr_pc_o", pc_o, 8'h00);

    // bit set/reset
    wr(2'd2, 8'hF0);
    wr(2'd3, 8'h07);
    chk("bsr_set3", pc_o, 8'hF8);
    wr(2'd3, 8'h0E);
    chk("bsr_clr7", pc_o, 8'h78);

    // mode 1 port A input
    wr(2'd3, 8'hB0);
    chk("a1in_pc_oe", pc_oe, 8'hEF);
    chk("a1in_pa_oe", pa_oe, 8'h00);
    wr(2'd3, 8'h09);
    pa_i = 8'hA5;
    pc_i[4] = 1'b0;
    tick(SYNC + 1);
    chk1("a1in_ibf_set", pc_o[5], 1'b1);
    chk1("a1in_intr_wait_rise", intr_a, 1'b0);
    pc_i[4] = 1'b1;
    tick(SYNC + 1);
    chk1("a1in_intr_set", intr_a, 1'b1);
    chk1("a1in_pc3_intr", pc_o[3], 1'b1);
    peek(2'd2, got);
    chk("a1in_status", got, 8'h38);
    rd(2'd0, got);
    chk("a1in_read_pa", got, 8'hA5);
    chk1("a1in_ibf_clr", pc_o[5], 1'b0);
    chk1("a1in_intr_clr", intr_a, 1'b0);

    // control write on the same edge as a STB fall wins
    wr(2'd3, 8'h09);
    pc_i[4] = 1'b0;
    tick(SYNC);
    wr(2'd3, 8'hB0);
    chk1("ctl_wins_ibf", pc_o[5], 1'b0);
    pc_i[4] = 1'b1;
    tick(SYNC + 2);
    chk1("ctl_wins_no_intr", intr_a, 1'b0);

    // mode 1 port B output
    wr(2'd3, 8'h84);
    chk("b1out_pc_oe", pc_oe, 8'hFB);
    chk("b1out_pb_oe", pb_oe, 8'hFF);
    wr(2'd3, 8'h05);
    wr(2'd1, 8'h77);
    chk("b1out_pb_o", pb_o, 8'h77);
    chk1("b1out_obf_low", pc_o[1], 1'b0);
    pc_i[2] = 1'b0;
    tick(SYNC + 1);
    chk1("b1out_obf_high", pc_o[1], 1'b1);
    chk1("b1out_intr_wait_rise", intr_b, 1'b0);
    pc_i[2] = 1'b1;
    tick(SYNC + 1);
    chk1("b1out_intr_set", intr_b, 1'b1);
    peek(2'd2, got);
    chk("b1out_status", got, 8'h07);
    wr(2'd1, 8'h88);
    chk1("b1out_intr_clr", intr_b, 1'b0);
    chk1("b1out_obf_low2", pc_o[1], 1'b0);

    // CPU write on the same edge as an ACK fall: OBF_n stays low
    pc_i[2] = 1'b0;
    tick(SYNC + 1);
    pc_i[2] = 1'b1;
    tick(SYNC + 2);
    chk1("b1out_intr_again", intr_b, 1'b1);
    pc_i[2] = 1'b0;
    tick(SYNC);
    wr(2'd1, 8'h99);
    chk1("wr_ack_obf_low", pc_o[1], 1'b0);
    chk("wr_ack_pb_o", pb_o, 8'h99);
    chk1("wr_ack_intr_clr", intr_b, 1'b0);
    pc_i[2] = 1'b1;
    tick(SYNC + 2);
    chk1("wr_ack_no_intr", intr_b, 1'b0);

    // randomized mode 0 (including unsupported mode 2 codes)
    wr(2'd3, 8'h9B);
    m_ctrl = 8'h9B; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00;
    for (int it = 0; it < 24; it++) begin
      pa_i = 8'($urandom); pb_i = 8'($urandom); pc_i = 8'($urandom);
      op = $urandom_range(0, 4);
      d  = 8'($urandom);
      case (op)
        0: begin
          mm = $urandom_range(0, 2);
          md = (mm == 0) ? 2'b00 : ((mm == 1) ? 2'b10 : 2'b11);
          r  = 8'($urandom);
          w  = {1'b1, md, r[4:3], 1'b0, r[1:0]};
          wr(2'd3, w);
          m_ctrl = w; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00;
        end
        1: begin wr(2'd0, d); m_pa = d; end
        2: begin wr(2'd1, d); m_pb = d; end
        3: begin wr(2'd2, d); m_pc = d; end
        default: begin
          bi = $urandom_range(0, 7);
          v  = 1'($urandom_range(0, 1));
          wr(2'd3, {4'b0000, 3'(bi), v});
          m_pc[bi] = v;
        end
      endcase
      tick(SYNC);
      chk("rnd_pa_oe", pa_oe, m_ctrl[4] ? 8'h00 : 8'hFF);
      chk("rnd_pb_oe", pb_oe, m_ctrl[1] ? 8'h00 : 8'hFF);
      chk("rnd_pc_oe", pc_oe, {{4{~m_ctrl[3]}}, {4{~m_ctrl[0]}}});
      chk("rnd_pa_o", pa_o, m_pa);
      chk("rnd_pb_o", pb_o, m_pb);
      chk("rnd_pc_o", pc_o, m_pc);
      peek(2'd0, got);
      chk("rnd_pa_read", got, m_ctrl[4] ? pa_i : m_pa);
      peek(2'd1, got);
      chk("rnd_pb_read", got, m_ctrl[1] ? pb_i : m_pb);
      peek(2'd2, got);
      chk("rnd_pc_read", got, nib_sel(m_ctrl[3], m_ctrl[0], pc_i, m_pc));
      chk1("rnd_intr_a", intr_a, 1'b0);
      chk1("rnd_intr_b", intr_b, 1'b0);
    end

    // randomized mode 1 port A input transfers through a queue
    pc_i = 8'hFF;
    tick(SYNC + 2);
    wr(2'd3, 8'hB0);
    wr(2'd3, 8'h09);
    for (int it = 0; it < 8; it++) begin
      d = 8'($urandom);
      pa_i = d;
      exp_q.push_back(d);
      pc_i[4] = 1'b0;
      tick(SYNC + 1);
      pa_i = 8'($urandom);
      pc_i[4] = 1'b1;
      tick(SYNC + 2);
      chk1("q_ibf", pc_o[5], 1'b1);
      chk1("q_intr", intr_a, 1'b1);
      rd(2'd0, got);
      chk("q_data", got, exp_q.pop_front());
      chk1("q_ibf_clr", pc_o[5], 1'b0);
      chk1("q_intr_clr", intr_a, 1'b0);
    end

    // read PA on the same edge as the next STB fall
    pa_i = 8'h11;
    pc_i[4] = 1'b0;
    tick(SYNC + 1);
    pc_i[4] = 1'b1;
    tick(SYNC + 2);
    chk1("rdfall_first_intr", intr_a, 1'b1);
    pa_i = 8'h22;
    pc_i[4] = 1'b0;
    tick(SYNC);
    rd(2'd0, got);
    chk("rdfall_old_data", got, 8'h11);
    chk1("rdfall_ibf_stays", pc_o[5], 1'b1);
    chk1("rdfall_intr_clr", intr_a, 1'b0);
    peek(2'd0, got);
    chk("rdfall_new_data", got, 8'h22);
    pc_i[4] = 1'b1;
    tick(SYNC + 2);
    chk1("rdfall_intr_set", intr_a, 1'b1);

    // asynchronous reset in the middle of a handshake
    #3;
    reset_n = 1'b0;
    #1;
    chk1("async_rst_intr_a", intr_a, 1'b0);
    chk("async_rst_pc_o", pc_o, 8'h00);
    chk("async_rst_pc_oe", pc_oe, 8'h00);
    tick(1);
    reset_n = 1'b1;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
